// File: rtl/uart_loopback_fifo.sv
// Buffered UART echo: uart_rx -> FIFO -> uart_tx, with sticky overflow/frame-error flags.
// Optional UART_LOOPBACK_DROP_CNT_EN adds saturating drop and frame-error counters.

module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);
  localparam int BW = $clog2(DATA_WIDTH + 2);

  logic [DATA_WIDTH:0] shift_r;
  logic [BW-1:0]       bit_cnt_r;
  logic [18:0]         cnt_r;
  logic                txd_r;
  logic                busy_r;

  assign s_axis_tready = !busy_r;
  assign txd           = txd_r;
  assign busy          = busy_r;

  // Frame serializer: start bit on accept, then data LSB first, then stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r   <= {(DATA_WIDTH+1){1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      cnt_r     <= 19'd0;
      txd_r     <= 1'b1;
      busy_r    <= 1'b0;
    end else if (!busy_r) begin
      if (s_axis_tvalid) begin
        busy_r    <= 1'b1;
        txd_r     <= 1'b0;
        shift_r   <= {1'b1, s_axis_tdata};
        bit_cnt_r <= BW'(DATA_WIDTH + 1);
        cnt_r     <= {prescale, 3'b000} - 19'd1;
      end
    end else if (cnt_r != 19'd0) begin
      cnt_r <= cnt_r - 19'd1;
    end else if (bit_cnt_r != {BW{1'b0}}) begin
      txd_r     <= shift_r[0];
      shift_r   <= {1'b0, shift_r[DATA_WIDTH:1]};
      bit_cnt_r <= bit_cnt_r - BW'(1);
      cnt_r     <= {prescale, 3'b000} - 19'd1;
    end else begin
      busy_r <= 1'b0;
    end
  end
endmodule

module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t             state_r;
  logic                  rxd_r;
  logic                  rxd_d_r;
  logic [18:0]           cnt_r;
  logic [BW-1:0]         bit_cnt_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  tvalid_r;
  logic                  ferr_r;

  assign m_axis_tdata  = data_r;
  assign m_axis_tvalid = tvalid_r;
  assign frame_error   = ferr_r;
  assign busy          = (state_r != RX_IDLE);

  // Receiver FSM: falling edge starts a frame, every bit is sampled mid-cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RX_IDLE;
      rxd_r     <= 1'b1;
      rxd_d_r   <= 1'b1;
      cnt_r     <= 19'd0;
      bit_cnt_r <= {BW{1'b0}};
      data_r    <= {DATA_WIDTH{1'b0}};
      tvalid_r  <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      rxd_r   <= rxd;
      rxd_d_r <= rxd_r;
      ferr_r  <= 1'b0;
      if (tvalid_r && m_axis_tready) begin
        tvalid_r <= 1'b0;
      end
      case (state_r)
        RX_IDLE: begin
          if (rxd_d_r && !rxd_r) begin
            cnt_r   <= {1'b0, prescale, 2'b00} - 19'd1;
            state_r <= RX_START;
          end
        end
        RX_START: begin
          if (cnt_r != 19'd0) begin
            cnt_r <= cnt_r - 19'd1;
          end else if (!rxd_r) begin
            cnt_r     <= {prescale, 3'b000} - 19'd1;
            bit_cnt_r <= BW'(DATA_WIDTH);
            state_r   <= RX_DATA;
          end else begin
            state_r <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt_r != 19'd0) begin
            cnt_r <= cnt_r - 19'd1;
          end else begin
            data_r    <= {rxd_r, data_r[DATA_WIDTH-1:1]};
            cnt_r     <= {prescale, 3'b000} - 19'd1;
            bit_cnt_r <= bit_cnt_r - BW'(1);
            if (bit_cnt_r == BW'(1)) begin
              state_r <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (cnt_r != 19'd0) begin
            cnt_r <= cnt_r - 19'd1;
          end else begin
            tvalid_r <= rxd_r;
            ferr_r   <= !rxd_r;
            state_r  <= RX_IDLE;
          end
        end
        default: state_r <= RX_IDLE;
      endcase
    end
  end
endmodule

module uart_loopback_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_i,
  output logic          tx_o,
  input  logic [15:0]   prescale_i,
  input  logic          echo_en_i,
  input  logic          clr_status_i,
  output logic [CW-1:0] fifo_count_o,
  output logic          overflow_o,
  output logic          frame_err_o,
  output logic          busy_o
`ifdef UART_LOOPBACK_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt_o,
  output logic [7:0]    ferr_cnt_o
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;
  logic                  frame_err_r;
  logic [DATA_WIDTH-1:0] rx_data_s;
  logic                  rx_valid_s;
  logic                  rx_busy_s;
  logic                  rx_ferr_s;
  logic                  tx_ready_s;
  logic                  tx_busy_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  tx_valid_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  drop_s;

  assign full_s     = (count_r == CW'(FIFO_DEPTH));
  assign empty_s    = (count_r == {CW{1'b0}});
  assign tx_valid_s = !empty_s && echo_en_i;
  assign pop_s      = tx_valid_s && tx_ready_s;
  // A full FIFO that is draining this cycle still has room for the incoming word.
  assign push_s     = rx_valid_s && (!full_s || pop_s);
  assign drop_s     = rx_valid_s && full_s && !pop_s;

  assign fifo_count_o = count_r;
  assign overflow_o   = overflow_r;
  assign frame_err_o  = frame_err_r;
  assign busy_o       = rx_busy_s || tx_busy_s || !empty_s;

  uart_rx #(.DATA_WIDTH(DATA_WIDTH)) u_rx (
    .clk           (clk),
    .rst           (rst),
    .m_axis_tdata  (rx_data_s),
    .m_axis_tvalid (rx_valid_s),
    .m_axis_tready (1'b1),
    .rxd           (rx_i),
    .busy          (rx_busy_s),
    .frame_error   (rx_ferr_s),
    .prescale      (prescale_i)
  );

  uart_tx #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (mem_r[rd_ptr_r]),
    .s_axis_tvalid (tx_valid_s),
    .s_axis_tready (tx_ready_s),
    .txd           (tx_o),
    .busy          (tx_busy_s),
    .prescale      (prescale_i)
  );

  // FIFO storage: data array needs no reset, occupancy is tracked by pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rx_data_s;
    end
  end

  // FIFO pointers, occupancy and sticky status; a set event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_status_i) begin
        overflow_r <= 1'b0;
      end
      if (rx_ferr_s) begin
        frame_err_r <= 1'b1;
      end else if (clr_status_i) begin
        frame_err_r <= 1'b0;
      end
    end
  end

`ifdef UART_LOOPBACK_DROP_CNT_EN
  logic [7:0] drop_cnt_r;
  logic [7:0] ferr_cnt_r;

  assign drop_cnt_o = drop_cnt_r;
  assign ferr_cnt_o = ferr_cnt_r;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating event counters; an event coinciding with a clear counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
      ferr_cnt_r <= 8'd0;
    end else begin
      if (drop_s) begin
        drop_cnt_r <= clr_status_i ? 8'd1 : sat_inc(drop_cnt_r);
      end else if (clr_status_i) begin
        drop_cnt_r <= 8'd0;
      end
      if (rx_ferr_s) begin
        ferr_cnt_r <= clr_status_i ? 8'd1 : sat_inc(ferr_cnt_r);
      end else if (clr_status_i) begin
        ferr_cnt_r <= 8'd0;
      end
    end
  end
`endif
endmodule
